// File: rtl/rn_ram_arbiter_pkg.sv
// Shared types and default sizing for the Rn RAM arbiter.
// The FSM state and the "who was served last" flag live here so the top and the picker agree.
package rn_ram_arbiter_pkg;

  localparam int RN_ADDR_W    = 9;
  localparam int RN_DATA_W    = 32;
  localparam int RN_RD_LAT    = 2;
  localparam int RN_CLR_WORDS = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_WRITE,
    ST_READ,
    ST_READ_WAIT
  } state_t;

  typedef enum logic {
    SRC_WRITER = 1'b0,
    SRC_READER = 1'b1
  } src_t;

endpackage

// File: rtl/rn_ram_arbiter_rr_arb2.sv
// Two-way round-robin picker: one-hot select between writer and reader.
// On a tie the source that was not served last wins.
module rn_ram_arbiter_rr_arb2
  import rn_ram_arbiter_pkg::*;
(
  input  logic wr_req,
  input  logic rd_req,
  input  src_t last_served,
  output logic sel_wr,
  output logic sel_rd
);

  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sel_wr = 1'b0;
    sel_rd = 1'b0;
    if (wr_req && rd_req) begin
      sel_wr = (last_served == SRC_READER);
      sel_rd = (last_served == SRC_WRITER);
    end else begin
      sel_wr = wr_req;
      sel_rd = rd_req;
    end
  end

endmodule

// File: rtl/rn_ram_arbiter.sv
// Owns the single-port Rn RAM: serialises writer/reader word accesses and runs the
// per-frame clear of Rn[0..CLR_WORDS-1]. All outputs are registered.
module rn_ram_arbiter
  import rn_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W    = RN_ADDR_W,
  parameter int DATA_W    = RN_DATA_W,
  parameter int RD_LAT    = RN_RD_LAT,
  parameter int CLR_WORDS = RN_CLR_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_rden,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  localparam int CNT_W = 2;

  if (CLR_WORDS < 1 || CLR_WORDS > (1 << ADDR_W)) begin : g_bad_clr_words
    $error("rn_ram_arbiter: CLR_WORDS must be in 1..2**ADDR_W");
  end
  if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_rd_lat
    $error("rn_ram_arbiter: RD_LAT must be in 1..3");
  end

  state_t             state;
  src_t               last_served;
  logic [CNT_W-1:0]   lat_cnt;
  logic               sel_wr;
  logic               sel_rd;

  rn_ram_arbiter_rr_arb2 u_rr_arb2 (
    .wr_req      (wr_req),
    .rd_req      (rd_req),
    .last_served (last_served),
    .sel_wr      (sel_wr),
    .sel_rd      (sel_rd)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      last_served <= SRC_READER;
      lat_cnt     <= '0;
      wr_gnt      <= 1'b0;
      rd_gnt      <= 1'b0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      clr_busy    <= 1'b0;
      clr_done    <= 1'b0;
      ram_addr    <= '0;
      ram_data    <= '0;
      ram_rden    <= 1'b0;
      ram_wren    <= 1'b0;
    end else begin
      wr_gnt   <= 1'b0;
      rd_gnt   <= 1'b0;
      rd_valid <= 1'b0;
      clr_done <= 1'b0;
      ram_rden <= 1'b0;
      ram_wren <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (clr_start) begin
            state    <= ST_CLEAR;
            clr_busy <= 1'b1;
            ram_addr <= '0;
            ram_data <= '0;
            ram_wren <= 1'b1;
          end else if (sel_wr) begin
            state       <= ST_WRITE;
            wr_gnt      <= 1'b1;
            ram_addr    <= wr_addr;
            ram_data    <= wr_data;
            last_served <= SRC_WRITER;
          end else if (sel_rd) begin
            // Read enable goes out with the grant so rd_valid lands RD_LAT+1 after rd_gnt.
            state       <= ST_READ;
            rd_gnt      <= 1'b1;
            ram_rden    <= 1'b1;
            ram_addr    <= rd_addr;
            last_served <= SRC_READER;
          end
        end
        ST_CLEAR: begin
          if (ram_addr == ADDR_W'(CLR_WORDS - 1)) begin
            state    <= ST_IDLE;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            ram_addr <= ram_addr + ADDR_W'(1);
            ram_wren <= 1'b1;
          end
        end
        ST_WRITE: begin
          state    <= ST_IDLE;
          ram_wren <= 1'b1;
        end
        ST_READ: begin
          state   <= ST_READ_WAIT;
          lat_cnt <= '0;
        end
        ST_READ_WAIT: begin
          if (lat_cnt == CNT_W'(RD_LAT - 1)) begin
            state    <= ST_IDLE;
            rd_data  <= ram_q;
            rd_valid <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rn_ram_arbiter.sv
// Self-checking bench for rn_ram_arbiter: behavioural RAM, shadow memory and
// round-robin expectation model; two extra instances cover RD_LAT=1 and RD_LAT=3.
module tb_rn_ram_arbiter;

  localparam int ADDR_W    = 9;
  localparam int DATA_W    = 32;
  localparam int RD_LAT    = 2;
  localparam int CLR_WORDS = 11;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_req, rd_req, clr_start;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_gnt, rd_gnt, rd_valid, clr_busy, clr_done;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data, ram_q;
  logic              ram_rden, ram_wren;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: expected RAM contents and who was granted last.
  logic [DATA_W-1:0] model_mem [2**ADDR_W];
  bit                model_last_wr;

  always #5 clk = ~clk;

  rn_ram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .CLR_WORDS(CLR_WORDS)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_data(rd_data), .rd_valid(rd_valid),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_rden(ram_rden), .ram_wren(ram_wren),
    .ram_q(ram_q)
  );

  wire [79:0] all_outs = {wr_gnt, rd_gnt, rd_data, rd_valid, clr_busy, clr_done,
                          ram_addr, ram_data, ram_rden, ram_wren};

  // Behavioural single-port RAM: q appears RD_LAT cycles after the rden cycle.
  logic [DATA_W-1:0] ram_mem [2**ADDR_W];
  logic [DATA_W-1:0] q_pipe  [1:RD_LAT];
  always @(posedge clk) begin
    if (ram_wren) ram_mem[ram_addr] <= ram_data;
    q_pipe[1] <= ram_rden ? ram_mem[ram_addr] : 'x;
    for (int i = 2; i <= RD_LAT; i++) q_pipe[i] <= q_pipe[i-1];
  end
  assign ram_q = q_pipe[RD_LAT];

  // Read-only instances at other latencies, each backed by a fixed ROM pattern.
  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    return {a, 23'h05A3C1} ^ 32'hC0DE_0000;
  endfunction

  logic [1:0]        lx_rd_req;
  logic [ADDR_W-1:0] lx_rd_addr [2];
  wire  [1:0]        lx_rd_gnt;
  wire  [1:0]        lx_rd_valid;
  wire  [DATA_W-1:0] lx_rd_data [2];

  for (genvar g = 0; g < 2; g++) begin : g_lat
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [ADDR_W-1:0] x_ram_addr;
    logic [DATA_W-1:0] x_ram_data, x_ram_q;
    logic              x_rden, x_wren, x_wr_gnt, x_clr_busy, x_clr_done;
    logic [DATA_W-1:0] x_pipe [1:LAT];

    rn_ram_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(LAT), .CLR_WORDS(CLR_WORDS)
    ) u_dut (
      .clk(clk), .rst(rst),
      .wr_req(1'b0), .wr_addr('0), .wr_data('0), .wr_gnt(x_wr_gnt),
      .rd_req(lx_rd_req[g]), .rd_addr(lx_rd_addr[g]), .rd_gnt(lx_rd_gnt[g]),
      .rd_data(lx_rd_data[g]), .rd_valid(lx_rd_valid[g]),
      .clr_start(1'b0), .clr_busy(x_clr_busy), .clr_done(x_clr_done),
      .ram_addr(x_ram_addr), .ram_data(x_ram_data), .ram_rden(x_rden), .ram_wren(x_wren),
      .ram_q(x_ram_q)
    );

    always @(posedge clk) begin
      x_pipe[1] <= x_rden ? rom_word(x_ram_addr) : 'x;
      for (int i = 2; i <= LAT; i++) x_pipe[i] <= x_pipe[i-1];
    end
    assign x_ram_q = x_pipe[LAT];
  end

  // ---------------------------------------------------------------- helpers
  task automatic apply_reset();
    rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0; clr_start = 1'b0; lx_rd_req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_last_wr = 1'b0;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          output int wait_cyc, output bit wren_ok);
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    wait_cyc = -1; wren_ok = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (wr_gnt) begin wait_cyc = i; break; end
    end
    wr_req = 1'b0;
    if (wait_cyc > 0) begin
      model_mem[a]  = d;
      model_last_wr = 1'b1;
      @(negedge clk);
      wren_ok = ram_wren && !ram_rden && (ram_addr == a) && (ram_data == d);
    end
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, output int wait_cyc,
                         output int lat, output logic [DATA_W-1:0] data);
    rd_req = 1'b1; rd_addr = a;
    wait_cyc = -1; lat = -1; data = 'x;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (rd_gnt) begin wait_cyc = i; break; end
    end
    rd_req = 1'b0;
    if (wait_cyc > 0) begin
      model_last_wr = 1'b0;
      for (int i = 1; i <= 20; i++) begin
        @(negedge clk);
        if (rd_valid) begin lat = i; data = rd_data; break; end
      end
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    apply_reset();
    vectors++;
    if (all_outs !== '0) begin
      miscompares++; $display("FAIL reset_outs: got %h want 0", all_outs);
    end
    @(negedge clk);
    vectors++;
    if (all_outs !== '0) begin
      miscompares++; $display("FAIL idle_outs: got %h want 0", all_outs);
    end
  endtask

  task automatic test_write_read();
    int w, l; bit ok; logic [DATA_W-1:0] d;
    do_write(9'd5, 32'h0000_1234, w, ok);
    vectors++;
    if (w !== 1) begin miscompares++; $display("FAIL wr_gnt_wait: got %0d want 1", w); end
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL wr_ram_wren: got 0 want 1"); end
    do_read(9'd5, w, l, d);
    vectors++;
    if (w !== 1) begin miscompares++; $display("FAIL rd_gnt_wait: got %0d want 1", w); end
    vectors++;
    if (l !== RD_LAT + 1) begin
      miscompares++; $display("FAIL rd_latency: got %0d want %0d", l, RD_LAT + 1);
    end
    vectors++;
    if (d !== 32'h0000_1234) begin
      miscompares++; $display("FAIL rd_data: got %h want 00001234", d);
    end
  endtask

  task automatic test_round_robin();
    int grants = 0; bit exp_wr; logic [DATA_W-1:0] exp_q[$]; logic [DATA_W-1:0] e;
    wr_req = 1'b1; rd_req = 1'b1; wr_addr = 9'd20; rd_addr = 9'd20; wr_data = $urandom;
    for (int cyc = 0; cyc < 60 && !(grants == 4 && exp_q.size() == 0); cyc++) begin
      @(negedge clk);
      vectors++;
      if (ram_wren && ram_rden) begin
        miscompares++; $display("FAIL rr_wren_rden: got both 1 want exclusive");
      end
      if (wr_gnt || rd_gnt) begin
        exp_wr = !model_last_wr;
        vectors++;
        if (wr_gnt !== exp_wr || rd_gnt !== !exp_wr) begin
          miscompares++;
          $display("FAIL rr_order: got wr_gnt=%b rd_gnt=%b want wr_gnt=%b", wr_gnt, rd_gnt, exp_wr);
        end
        if (wr_gnt) begin
          model_mem[20] = wr_data; model_last_wr = 1'b1; wr_data = $urandom;
        end else begin
          exp_q.push_back(model_mem[20]); model_last_wr = 1'b0;
        end
        grants++;
        if (grants == 4) begin wr_req = 1'b0; rd_req = 1'b0; end
      end
      if (rd_valid) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL rr_rd_valid: got unexpected rd_valid want none");
        end else begin
          e = exp_q.pop_front();
          if (rd_data !== e) begin
            miscompares++; $display("FAIL rr_rd_data: got %h want %h", rd_data, e);
          end
        end
      end
    end
    wr_req = 1'b0; rd_req = 1'b0;
    vectors++;
    if (grants != 4 || exp_q.size() != 0) begin
      miscompares++; $display("FAIL rr_timeout: got %0d grants want 4", grants);
    end
  endtask

  task automatic test_clear();
    int w, l, busy_cnt = 0, done_cnt = 0, done_iter = -1; bit ok; logic [DATA_W-1:0] d;
    for (int a = 0; a <= 11; a++) do_write(ADDR_W'(a), 32'hFFFF_FFFF, w, ok);
    clr_start = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      clr_start = 1'b0;
      if (clr_busy) begin
        vectors++;
        if (!(ram_wren && ram_addr == ADDR_W'(busy_cnt) && ram_data == '0)) begin
          miscompares++;
          $display("FAIL clr_write: got wren=%b addr=%0d data=%h want 1/%0d/0",
                   ram_wren, ram_addr, ram_data, busy_cnt);
        end
        busy_cnt++;
      end
      if (clr_done) begin done_cnt++; done_iter = i; end
    end
    for (int a = 0; a < CLR_WORDS; a++) model_mem[a] = '0;
    vectors++;
    if (busy_cnt != CLR_WORDS) begin
      miscompares++; $display("FAIL clr_busy_len: got %0d want %0d", busy_cnt, CLR_WORDS);
    end
    vectors++;
    if (done_cnt != 1 || done_iter != CLR_WORDS + 1) begin
      miscompares++;
      $display("FAIL clr_done: got count=%0d at=%0d want 1 at %0d", done_cnt, done_iter, CLR_WORDS + 1);
    end
    for (int a = 0; a <= 11; a++) begin
      do_read(ADDR_W'(a), w, l, d);
      vectors++;
      if (d !== model_mem[a]) begin
        miscompares++; $display("FAIL clr_readback[%0d]: got %h want %h", a, d, model_mem[a]);
      end
    end
  endtask

  task automatic test_clear_vs_write();
    int w, l, busy_cnt = 0, done_cnt = 0, done_iter = -1, gnt_iter = -1;
    logic [DATA_W-1:0] wd, d;
    wd = $urandom;
    wr_req = 1'b1; wr_addr = 9'd100; wr_data = wd; clr_start = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) clr_start = 1'b0;
      if (i == 3) clr_start = 1'b1;
      if (i == 4) clr_start = 1'b0;
      if (clr_busy) busy_cnt++;
      if (clr_done) begin done_cnt++; done_iter = i; end
      if (wr_gnt && gnt_iter < 0) begin
        gnt_iter = i; wr_req = 1'b0;
        model_mem[100] = wd; model_last_wr = 1'b1;
      end
    end
    for (int a = 0; a < CLR_WORDS; a++) model_mem[a] = '0;
    vectors++;
    if (done_cnt != 1) begin
      miscompares++; $display("FAIL cw_done_count: got %0d want 1", done_cnt);
    end
    vectors++;
    if (busy_cnt != CLR_WORDS) begin
      miscompares++; $display("FAIL cw_busy_len: got %0d want %0d", busy_cnt, CLR_WORDS);
    end
    vectors++;
    if (gnt_iter < 0 || gnt_iter != done_iter + 1) begin
      miscompares++; $display("FAIL cw_gnt_after_done: got gnt@%0d done@%0d want gnt=done+1", gnt_iter, done_iter);
    end
    do_read(9'd100, w, l, d);
    vectors++;
    if (d !== wd) begin miscompares++; $display("FAIL cw_readback: got %h want %h", d, wd); end
  endtask

  task automatic test_reset_abort();
    int w, l, stray = 0; bit ok, found = 1'b0; logic [DATA_W-1:0] d;
    // Abort a read sitting in its latency wait.
    rd_req = 1'b1; rd_addr = 9'd5;
    for (int i = 0; i < 60 && !rd_gnt; i++) @(negedge clk);
    rd_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (all_outs !== '0) begin
      miscompares++; $display("FAIL abort_read_outs: got %h want 0", all_outs);
    end
    rst = 1'b0; model_last_wr = 1'b0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (rd_valid) stray++; end
    vectors++;
    if (stray != 0) begin miscompares++; $display("FAIL abort_read_valid: got %0d pulses want 0", stray); end
    // Abort a clear at address 4.
    clr_start = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      clr_start = 1'b0;
      if (clr_busy && ram_addr == 9'd4) begin found = 1'b1; break; end
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL abort_clr_reach: got no addr 4 want addr 4"); end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (all_outs !== '0) begin
      miscompares++; $display("FAIL abort_clr_outs: got %h want 0", all_outs);
    end
    rst = 1'b0; stray = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (clr_done || clr_busy) stray++; end
    vectors++;
    if (stray != 0) begin miscompares++; $display("FAIL abort_clr_done: got %0d cycles want 0", stray); end
    do_write(9'd5, 32'h0000_1234, w, ok);
    vectors++;
    if (w !== 1 || !ok) begin miscompares++; $display("FAIL post_rst_write: got wait=%0d ok=%b want 1/1", w, ok); end
    do_read(9'd5, w, l, d);
    vectors++;
    if (l !== RD_LAT + 1 || d !== 32'h0000_1234) begin
      miscompares++; $display("FAIL post_rst_read: got lat=%0d data=%h want %0d/00001234", l, d, RD_LAT + 1);
    end
  endtask

  task automatic test_random();
    bit pend_wr = 1'b1, pend_rd = 1'b1, drv_wr, drv_rd, exp_wr;
    logic [ADDR_W-1:0] wa, ra; logic [DATA_W-1:0] wd, e;
    logic [DATA_W-1:0] exp_q[$]; int gnt_cyc_q[$]; int gc;
    apply_reset();
    wa = ADDR_W'($urandom_range(16, 47)); wd = $urandom; ra = ADDR_W'($urandom_range(16, 47));
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!pend_wr && cyc < 300 && $urandom_range(0, 2) == 0) begin
        pend_wr = 1'b1; wa = ADDR_W'($urandom_range(16, 47)); wd = $urandom;
      end
      if (!pend_rd && cyc < 300 && $urandom_range(0, 2) == 0) begin
        pend_rd = 1'b1; ra = ADDR_W'($urandom_range(16, 47));
      end
      wr_req = pend_wr; wr_addr = wa; wr_data = wd; rd_req = pend_rd; rd_addr = ra;
      drv_wr = pend_wr; drv_rd = pend_rd;
      @(negedge clk);
      if (ram_wren && ram_rden) begin
        vectors++; miscompares++; $display("FAIL rnd_wren_rden: got both 1 want exclusive");
      end
      if (wr_gnt || rd_gnt) begin
        exp_wr = (drv_wr && drv_rd) ? !model_last_wr : drv_wr;
        vectors++;
        if (!(drv_wr || drv_rd) || wr_gnt !== exp_wr || rd_gnt !== !exp_wr) begin
          miscompares++;
          $display("FAIL rnd_grant: got wr_gnt=%b rd_gnt=%b want wr_gnt=%b (req %b%b)",
                   wr_gnt, rd_gnt, exp_wr, drv_wr, drv_rd);
        end
        if (wr_gnt && drv_wr) begin
          model_mem[wa] = wd; model_last_wr = 1'b1; pend_wr = 1'b0;
        end else if (rd_gnt && drv_rd) begin
          exp_q.push_back(model_mem[ra]); gnt_cyc_q.push_back(cyc);
          model_last_wr = 1'b0; pend_rd = 1'b0;
        end
      end
      if (rd_valid) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL rnd_rd_valid: got unexpected rd_valid want none");
        end else begin
          e = exp_q.pop_front(); gc = gnt_cyc_q.pop_front();
          if (rd_data !== e || cyc - gc != RD_LAT + 1) begin
            miscompares++;
            $display("FAIL rnd_read: got data=%h lat=%0d want %h/%0d", rd_data, cyc - gc, e, RD_LAT + 1);
          end
        end
      end
    end
    wr_req = 1'b0; rd_req = 1'b0;
    vectors++;
    if (pend_wr || pend_rd || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL rnd_drain: got pending wr=%b rd=%b reads=%0d want none", pend_wr, pend_rd, exp_q.size());
    end
  endtask

  task automatic test_rd_latency();
    int lat, want; bit got_gnt; logic [DATA_W-1:0] d;
    for (int i = 0; i < 2; i++) begin
      want = ((i == 0) ? 1 : 3) + 1;
      lx_rd_addr[i] = ADDR_W'($urandom);
      lx_rd_req[i] = 1'b1;
      got_gnt = 1'b0; lat = -1; d = 'x;
      for (int c = 0; c < 60; c++) begin
        @(negedge clk);
        if (lx_rd_gnt[i]) begin got_gnt = 1'b1; break; end
      end
      lx_rd_req[i] = 1'b0;
      if (got_gnt) begin
        for (int c = 1; c <= 20; c++) begin
          @(negedge clk);
          if (lx_rd_valid[i]) begin lat = c; d = lx_rd_data[i]; break; end
        end
      end
      vectors++;
      if (lat != want || d !== rom_word(lx_rd_addr[i])) begin
        miscompares++;
        $display("FAIL lat_build%0d: got lat=%0d data=%h want %0d/%h",
                 i, lat, d, want, rom_word(lx_rd_addr[i]));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    lx_rd_addr[0] = '0; lx_rd_addr[1] = '0;
    for (int a = 0; a < 2**ADDR_W; a++) begin model_mem[a] = '0; ram_mem[a] = '0; end
    test_reset();
    test_write_read();
    test_round_robin();
    test_clear();
    test_clear_vs_write();
    test_reset_abort();
    test_random();
    test_rd_latency();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
